fan_step_scheduler: RTL and testbench
=====================================

Name: fan_step_scheduler

Overview:
Sequences one control step of the fan controller datapath. It generates the controller time-step tick from the system clock and takes 2^AVG_LOG2 spaced ADC samples. It presents the averaged ADC value and the latched setpoint to the PID/PWM datapath with a start/done handshake, and supervises that handshake with a timeout. It sits between the top-level pins and the FanCTRL datapath, and replaces the free-running clock-enable.

Parameters:
ADC_BITWIDTH, 4, width of ADC and setpoint values
PRESCALE, 200000, clock cycles per control step (200 ms at 1 MHz); must be >= 2
AVG_LOG2, 2, log2 of the number of ADC samples averaged per step (0 means a single sample)
SAMPLE_GAP, 16, clock cycles between consecutive ADC samples; must be >= 1
TIMEOUT, 64, maximum number of WAIT_DONE cycles before a fault is raised

Ports:
clk_i  input  1  system clock; single clock domain
rst_i  input  1  synchronous reset, active-high
enable_i  input  1  scheduler enable; low forces IDLE
ADC_value_i  input  ADC_BITWIDTH  raw ADC reading
SET_value_i  input  ADC_BITWIDTH  setpoint
pid_done_i  input  1  one-cycle pulse from datapath: step computation finished
adc_avg_o  output  ADC_BITWIDTH  averaged ADC value for the datapath
set_o  output  ADC_BITWIDTH  setpoint latched for the current step
pid_start_o  output  1  one-cycle start pulse to the datapath
step_count_o  output  8  completed-step counter; wraps from 255 to 0
overrun_o  output  1  sticky: a tick arrived while a step was still in progress
fault_o  output  1  sticky: datapath did not answer within TIMEOUT cycles
state_o  output  3  FSM state: IDLE=0, WAIT_TICK=1, SAMPLE=2, START=3, WAIT_DONE=4, FAULT=5

Behaviour:
- Reset (rst_i=1 at a clock edge): all outputs 0, state IDLE, all counters and the accumulator cleared. Reset has priority over every other input, including mid-step.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable_i=1 in any state except IDLE and FAULT; it is held at 0 in IDLE and FAULT.
  - tick=1 when count==PRESCALE-1; the counter then wraps to 0.
  - The first tick after leaving IDLE comes PRESCALE cycles after leaving IDLE.
- IDLE -> WAIT_TICK when enable_i=1.
- WAIT_TICK -> SAMPLE on tick.
  - On that edge: accumulator cleared, sample counter cleared, gap counter cleared.
- SAMPLE:
  - The gap counter increments every cycle.
  - When gap==SAMPLE_GAP-1: accumulator += ADC_value_i, gap counter -> 0, sample counter++.
  - On the edge that adds sample number 2^AVG_LOG2:
    - adc_avg_o <= (acc + ADC_value_i) >> AVG_LOG2 (truncating).
    - set_o <= SET_value_i.
    - State -> START.
  - Accumulator width is ADC_BITWIDTH+AVG_LOG2; it cannot overflow.
- START:
  - pid_start_o=1 for exactly this cycle (registered output).
  - Always -> WAIT_DONE.
  - pid_done_i is ignored in START.
- WAIT_DONE:
  - The timeout counter starts at 0 on entry and increments each cycle.
  - pid_done_i=1 -> WAIT_TICK and step_count_o++.
  - If the timeout counter reaches TIMEOUT-1 with no done -> FAULT and fault_o<=1.
  - If done and timeout occur in the same cycle, done wins.
- Latency: for a tick at cycle T, samples are taken at T+k*SAMPLE_GAP for k=1..N (N=2^AVG_LOG2). pid_start_o is high at cycle T+N*SAMPLE_GAP+1.
- Overrun:
  - A tick seen in SAMPLE, START or WAIT_DONE sets overrun_o and is otherwise discarded.
  - The step in progress completes normally; the next step waits for the next tick.
- FAULT:
  - Holds until enable_i=0 or reset.
  - pid_start_o=0.
  - adc_avg_o and set_o hold their values.
- enable_i=0 in any state:
  - Next state is IDLE and the prescaler clears.
  - fault_o and overrun_o clear.
  - pid_start_o=0.
  - adc_avg_o, set_o and step_count_o hold.
  - A step in progress is abandoned; a later pid_done_i is ignored.
- Outputs adc_avg_o and set_o change only on the final-sample edge, so they are stable from START through WAIT_DONE.

Test Plan:
1. Bench parameters PRESCALE=20, AVG_LOG2=2, SAMPLE_GAP=2, TIMEOUT=8. Reset, then enable_i=1 with ADC sequence 3,4,5,7 at the sample instants and SET=9, done 3 cycles after start -> adc_avg_o=4, set_o=9, a single 1-cycle pid_start_o at tick+9, step_count_o=1, state returns to WAIT_TICK.
2. Never assert pid_done_i -> FAULT (state_o=5) and fault_o=1 on the 8th WAIT_DONE cycle; no further pid_start_o over 100 cycles; enable_i low for 1 cycle -> fault_o=0, state IDLE.
3. Assert pid_done_i together with the last timeout cycle -> no fault, step_count_o increments.
4. Hold done off for 15 cycles (TIMEOUT=32 variant) so a tick lands in WAIT_DONE -> overrun_o=1; the step completes when done arrives; the next pid_start_o follows the subsequent tick.
5. Assert rst_i in mid-SAMPLE with acc non-zero -> next cycle all outputs 0, state IDLE; re-run scenario 1 and get identical results. Run 256 steps -> step_count_o wraps to 0.
6. AVG_LOG2=0, ADC=15 -> adc_avg_o=15 with pid_start_o at tick+SAMPLE_GAP+1.

Source files
------------

// File: rtl/fan_step_scheduler.sv
// Control-step sequencer for the fan controller: step tick, ADC averaging,
// start/done handshake with the PID/PWM datapath and timeout supervision.
module fan_step_scheduler #(
    parameter int unsigned ADC_BITWIDTH = 4,
    parameter int unsigned PRESCALE     = 200000,
    parameter int unsigned AVG_LOG2     = 2,
    parameter int unsigned SAMPLE_GAP   = 16,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [ADC_BITWIDTH-1:0] ADC_value_i,
    input  logic [ADC_BITWIDTH-1:0] SET_value_i,
    input  logic                    pid_done_i,
    output logic [ADC_BITWIDTH-1:0] adc_avg_o,
    output logic [ADC_BITWIDTH-1:0] set_o,
    output logic                    pid_start_o,
    output logic [7:0]              step_count_o,
    output logic                    overrun_o,
    output logic                    fault_o,
    output logic [2:0]              state_o
);

    localparam int unsigned CNT_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned GAP_W       = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
    localparam int unsigned TO_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SMP_W       = AVG_LOG2 + 1;
    localparam int unsigned ACC_W       = ADC_BITWIDTH + AVG_LOG2;
    localparam int unsigned NUM_SAMPLES = 2 ** AVG_LOG2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        SAMPLE    = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   pre_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [SMP_W-1:0]   smp_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [ACC_W-1:0]   acc_q;

    logic               run_c;
    logic               tick_c;
    logic               gap_hit_c;
    logic               last_smp_c;
    logic               timeout_c;
    logic [ACC_W-1:0]   sum_c;

    // Prescaler runs only while a step cycle is active; the tick is its wrap point
    assign run_c      = enable_i && (state_q != IDLE) && (state_q != FAULT);
    assign tick_c     = run_c && (pre_cnt_q == CNT_W'(PRESCALE - 1));
    assign gap_hit_c  = (gap_cnt_q == GAP_W'(SAMPLE_GAP - 1));
    assign last_smp_c = (smp_cnt_q == SMP_W'(NUM_SAMPLES - 1));
    assign timeout_c  = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign sum_c      = acc_q + ACC_W'(ADC_value_i);
    assign state_o    = state_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping enable abandons whatever is in flight
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = WAIT_TICK;
                WAIT_TICK: if (tick_c) state_d = SAMPLE;
                SAMPLE:    if (gap_hit_c && last_smp_c) state_d = START;
                START:     state_d = WAIT_DONE;
                WAIT_DONE: begin
                    if (pid_done_i) begin
                        state_d = WAIT_TICK;
                    end else if (timeout_c) begin
                        state_d = FAULT;
                    end
                end
                FAULT:     state_d = FAULT;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Step-tick prescaler
    always_ff @(posedge clk_i) begin
        if (rst_i || !run_c || tick_c) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_q + CNT_W'(1);
        end
    end

    // Sample spacing, sample count and accumulation
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gap_cnt_q <= '0;
            smp_cnt_q <= '0;
            acc_q     <= '0;
        end else if (state_q == WAIT_TICK && state_d == SAMPLE) begin
            gap_cnt_q <= '0;
            smp_cnt_q <= '0;
            acc_q     <= '0;
        end else if (state_q == SAMPLE && enable_i) begin
            if (gap_hit_c) begin
                gap_cnt_q <= '0;
                smp_cnt_q <= smp_cnt_q + SMP_W'(1);
                acc_q     <= sum_c;
            end else begin
                gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
        end
    end

    // Average and setpoint change only on the final-sample edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adc_avg_o <= '0;
            set_o     <= '0;
        end else if (state_q == SAMPLE && state_d == START) begin
            adc_avg_o <= ADC_BITWIDTH'(sum_c >> AVG_LOG2);
            set_o     <= SET_value_i;
        end
    end

    // Handshake, step counting and sticky supervision flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pid_start_o  <= 1'b0;
            to_cnt_q     <= '0;
            step_count_o <= 8'd0;
            overrun_o    <= 1'b0;
            fault_o      <= 1'b0;
        end else begin
            pid_start_o <= (state_d == START);
            to_cnt_q    <= (state_q == WAIT_DONE) ? to_cnt_q + TO_W'(1) : '0;
            if (state_q == WAIT_DONE && state_d == WAIT_TICK) begin
                step_count_o <= step_count_o + 8'd1;
            end
            if (!enable_i) begin
                overrun_o <= 1'b0;
            end else if (tick_c && (state_q inside {SAMPLE, START, WAIT_DONE})) begin
                overrun_o <= 1'b1;
            end
            if (!enable_i) begin
                fault_o <= 1'b0;
            end else if (state_q == WAIT_DONE && state_d == FAULT) begin
                fault_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fan_step_scheduler.sv
// Scenario bench for fan_step_scheduler: three instances cover the
// TIMEOUT=8, TIMEOUT=32 and single-sample configurations.
module tb_fan_step_scheduler;

    typedef struct {
        int         id;
        logic [3:0] avg;
        logic [3:0] setv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] adc;
    logic [3:0] setv;
    logic       en   [3];
    logic       done [3];
    logic [3:0] avg  [3];
    logic [3:0] so   [3];
    logic       ps   [3];
    logic [7:0] sc   [3];
    logic       ov   [3];
    logic       ft   [3];
    logic [2:0] st   [3];

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    fan_step_scheduler #(.ADC_BITWIDTH(4), .PRESCALE(20), .AVG_LOG2(2), .SAMPLE_GAP(2), .TIMEOUT(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .ADC_value_i(adc), .SET_value_i(setv),
        .pid_done_i(done[0]), .adc_avg_o(avg[0]), .set_o(so[0]), .pid_start_o(ps[0]),
        .step_count_o(sc[0]), .overrun_o(ov[0]), .fault_o(ft[0]), .state_o(st[0]));

    fan_step_scheduler #(.ADC_BITWIDTH(4), .PRESCALE(20), .AVG_LOG2(2), .SAMPLE_GAP(2), .TIMEOUT(32)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .ADC_value_i(adc), .SET_value_i(setv),
        .pid_done_i(done[1]), .adc_avg_o(avg[1]), .set_o(so[1]), .pid_start_o(ps[1]),
        .step_count_o(sc[1]), .overrun_o(ov[1]), .fault_o(ft[1]), .state_o(st[1]));

    fan_step_scheduler #(.ADC_BITWIDTH(4), .PRESCALE(20), .AVG_LOG2(0), .SAMPLE_GAP(2), .TIMEOUT(8)) dut_c (
        .clk_i(clk), .rst_i(rst), .enable_i(en[2]), .ADC_value_i(adc), .SET_value_i(setv),
        .pid_done_i(done[2]), .adc_avg_o(avg[2]), .set_o(so[2]), .pid_start_o(ps[2]),
        .step_count_o(sc[2]), .overrun_o(ov[2]), .fault_o(ft[2]), .state_o(st[2]));

    // Scoreboard: every start pulse must match the oldest expected step result
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ps[d] === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected_start inst=%0d avg=%0d set=%0d expected no start", d, avg[d], so[d]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.id != d || avg[d] !== e.avg || so[d] !== e.setv)
                        $display("FAIL sb_step_result inst=%0d avg=%0d set=%0d expected inst=%0d avg=%0d set=%0d",
                                 d, avg[d], so[d], e.id, e.avg, e.setv);
                    else
                        passed++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int nsamp(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    // Wait (bounded) until instance d reports state s; n = negedges waited, -1 on expiry
    task automatic wait_state(input int d, input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (st[d] !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (st[d] !== s) n = -1;
    endtask

    // Called at the first SAMPLE cycle (tick+1); returns at tick+N*GAP+1
    task automatic drive_samples(input int d, input logic [3:0] v [4], input logic [3:0] s);
        int   sum;
        exp_t e;
        sum  = 0;
        setv = s;
        for (int k = 0; k < nsamp(d); k++) sum += int'(v[k]);
        e.id   = d;
        e.avg  = 4'(sum >> ((d == 2) ? 0 : 2));
        e.setv = s;
        sb.push_back(e);
        for (int k = 0; k < nsamp(d); k++) begin
            adc = v[k];
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({st[d], avg[d], so[d], ps[d], sc[d], ov[d], ft[d]} !== 22'd0)
                $display("FAIL reset_outputs inst=%0d got=%h expected=0", d,
                         {st[d], avg[d], so[d], ps[d], sc[d], ov[d], ft[d]});
            else passed++;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (st[0] !== 3'd0) $display("FAIL idle_without_enable state=%0d expected=0", st[0]);
        else passed++;
    endtask

    task automatic test_basic_step();
        int         n;
        logic [3:0] v [4];
        en[0] = 1'b1;
        wait_state(0, 3'd2, 100, n);
        checks++;
        if (n != 21) $display("FAIL t1_first_tick cycles=%0d expected=21", n); else passed++;
        v = '{4'd3, 4'd4, 4'd5, 4'd7};
        drive_samples(0, v, 4'd9);
        checks++;
        if (ps[0] !== 1'b1) $display("FAIL t1_start_at_tick_plus_9 start=%b expected=1", ps[0]); else passed++;
        @(negedge clk);
        checks++;
        if (ps[0] !== 1'b0 || st[0] !== 3'd4)
            $display("FAIL t1_start_single_cycle start=%b state=%0d expected start=0 state=4", ps[0], st[0]);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        done[0] = 1'b1;
        @(negedge clk);
        done[0] = 1'b0;
        checks++;
        if (st[0] !== 3'd1 || sc[0] !== 8'd1 || avg[0] !== 4'd4 || so[0] !== 4'd9)
            $display("FAIL t1_step_complete state=%0d count=%0d avg=%0d set=%0d expected 1 1 4 9",
                     st[0], sc[0], avg[0], so[0]);
        else passed++;
    endtask

    task automatic test_timeout();
        int         n;
        int         cnt;
        logic [3:0] v [4];
        wait_state(0, 3'd2, 100, n);
        checks++;
        if (n != 8) $display("FAIL t2_periodic_tick cycles=%0d expected=8", n); else passed++;
        v = '{4'd1, 4'd2, 4'd3, 4'd4};
        drive_samples(0, v, 4'd5);
        checks++;
        if (ps[0] !== 1'b1) $display("FAIL t2_start start=%b expected=1", ps[0]); else passed++;
        n = 0;
        @(negedge clk);
        while (st[0] === 3'd4 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8) $display("FAIL t2_wait_done_cycles cycles=%0d expected=8", n); else passed++;
        checks++;
        if (st[0] !== 3'd5 || ft[0] !== 1'b1)
            $display("FAIL t2_fault_entry state=%0d fault=%b expected state=5 fault=1", st[0], ft[0]);
        else passed++;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (ps[0] === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0 || st[0] !== 3'd5 || avg[0] !== 4'd2 || so[0] !== 4'd5)
            $display("FAIL t2_fault_hold starts=%0d state=%0d avg=%0d set=%0d expected 0 5 2 5",
                     cnt, st[0], avg[0], so[0]);
        else passed++;
        en[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (st[0] !== 3'd0 || ft[0] !== 1'b0 || sc[0] !== 8'd1 || avg[0] !== 4'd2)
            $display("FAIL t2_disable_clears state=%0d fault=%b count=%0d avg=%0d expected 0 0 1 2",
                     st[0], ft[0], sc[0], avg[0]);
        else passed++;
        en[0] = 1'b1;
    endtask

    task automatic test_done_at_timeout();
        int         n;
        logic [3:0] v [4];
        wait_state(0, 3'd2, 100, n);
        checks++;
        if (n != 21) $display("FAIL t3_tick_after_reenable cycles=%0d expected=21", n); else passed++;
        v = '{4'd15, 4'd15, 4'd15, 4'd15};
        drive_samples(0, v, 4'd0);
        repeat (8) @(negedge clk);
        done[0] = 1'b1;
        @(negedge clk);
        done[0] = 1'b0;
        checks++;
        if (st[0] !== 3'd1 || ft[0] !== 1'b0 || sc[0] !== 8'd2)
            $display("FAIL t3_done_wins state=%0d fault=%b count=%0d expected 1 0 2", st[0], ft[0], sc[0]);
        else passed++;
        en[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_overrun();
        int         n;
        logic [3:0] v [4];
        en[1] = 1'b1;
        wait_state(1, 3'd2, 100, n);
        v = '{4'd8, 4'd8, 4'd9, 4'd9};
        drive_samples(1, v, 4'd12);
        repeat (11) @(negedge clk);
        checks++;
        if (ov[1] !== 1'b0) $display("FAIL t4_no_overrun_before_tick overrun=%b expected=0", ov[1]); else passed++;
        @(negedge clk);
        checks++;
        if (ov[1] !== 1'b1 || st[1] !== 3'd4)
            $display("FAIL t4_overrun_set overrun=%b state=%0d expected 1 4", ov[1], st[1]);
        else passed++;
        repeat (3) @(negedge clk);
        done[1] = 1'b1;
        @(negedge clk);
        done[1] = 1'b0;
        checks++;
        if (st[1] !== 3'd1 || sc[1] !== 8'd1 || ov[1] !== 1'b1)
            $display("FAIL t4_step_completes state=%0d count=%0d overrun=%b expected 1 1 1", st[1], sc[1], ov[1]);
        else passed++;
        wait_state(1, 3'd2, 100, n);
        checks++;
        if (n != 16) $display("FAIL t4_next_step_on_next_tick cycles=%0d expected=16", n); else passed++;
        v = '{4'd0, 4'd0, 4'd0, 4'd1};
        drive_samples(1, v, 4'd3);
        @(negedge clk);
        done[1] = 1'b1;
        @(negedge clk);
        done[1] = 1'b0;
        checks++;
        if (sc[1] !== 8'd2) $display("FAIL t4_second_step count=%0d expected=2", sc[1]); else passed++;
        en[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (ov[1] !== 1'b0) $display("FAIL t4_overrun_cleared overrun=%b expected=0", ov[1]); else passed++;
    endtask

    task automatic test_reset_mid_sample();
        int         n;
        logic [3:0] v [4];
        en[0] = 1'b1;
        wait_state(0, 3'd2, 100, n);
        setv = 4'd6;
        adc  = 4'd7;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({st[0], avg[0], so[0], ps[0], sc[0], ov[0], ft[0]} !== 22'd0)
            $display("FAIL t5_reset_mid_sample got=%h expected=0", {st[0], avg[0], so[0], ps[0], sc[0], ov[0], ft[0]});
        else passed++;
        rst = 1'b0;
        wait_state(0, 3'd2, 100, n);
        checks++;
        if (n != 21) $display("FAIL t5_rerun_first_tick cycles=%0d expected=21", n); else passed++;
        v = '{4'd3, 4'd4, 4'd5, 4'd7};
        drive_samples(0, v, 4'd9);
        checks++;
        if (ps[0] !== 1'b1) $display("FAIL t5_rerun_start start=%b expected=1", ps[0]); else passed++;
        repeat (3) @(negedge clk);
        done[0] = 1'b1;
        @(negedge clk);
        done[0] = 1'b0;
        checks++;
        if (st[0] !== 3'd1 || sc[0] !== 8'd1 || avg[0] !== 4'd4 || so[0] !== 4'd9)
            $display("FAIL t5_rerun_result state=%0d count=%0d avg=%0d set=%0d expected 1 1 4 9",
                     st[0], sc[0], avg[0], so[0]);
        else passed++;
    endtask

    task automatic test_count_wrap();
        int         n;
        bit         stalled;
        logic [3:0] v [4];
        logic [3:0] s;
        stalled = 1'b0;
        for (int i = 2; i <= 256 && !stalled; i++) begin
            wait_state(0, 3'd2, 100, n);
            if (n < 0) begin
                stalled = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) v[k] = 4'($urandom_range(15, 0));
                s = 4'($urandom_range(15, 0));
                drive_samples(0, v, s);
                @(negedge clk);
                done[0] = 1'b1;
                @(negedge clk);
                done[0] = 1'b0;
                if (i == 255) begin
                    checks++;
                    if (sc[0] !== 8'd255) $display("FAIL t5_count_255 count=%0d expected=255", sc[0]);
                    else passed++;
                end
            end
        end
        checks++;
        if (stalled || sc[0] !== 8'd0)
            $display("FAIL t5_count_wrap count=%0d stalled=%0d expected count=0 stalled=0", sc[0], stalled);
        else passed++;
        en[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_sample();
        int         n;
        logic [3:0] v [4];
        en[2] = 1'b1;
        wait_state(2, 3'd2, 100, n);
        checks++;
        if (n != 21) $display("FAIL t6_first_tick cycles=%0d expected=21", n); else passed++;
        v = '{4'd15, 4'd0, 4'd0, 4'd0};
        drive_samples(2, v, 4'd6);
        checks++;
        if (ps[2] !== 1'b1) $display("FAIL t6_start_at_tick_plus_3 start=%b expected=1", ps[2]); else passed++;
        @(negedge clk);
        done[2] = 1'b1;
        @(negedge clk);
        done[2] = 1'b0;
        checks++;
        if (sc[2] !== 8'd1 || avg[2] !== 4'd15)
            $display("FAIL t6_single_sample count=%0d avg=%0d expected 1 15", sc[2], avg[2]);
        else passed++;
        wait_state(2, 3'd2, 100, n);
        v = '{4'd9, 4'd0, 4'd0, 4'd0};
        drive_samples(2, v, 4'd4);
        @(negedge clk);
        en[2] = 1'b0;
        @(negedge clk);
        en[2]   = 1'b1;
        done[2] = 1'b1;
        @(negedge clk);
        done[2] = 1'b0;
        checks++;
        if (sc[2] !== 8'd1 || st[2] !== 3'd1 || avg[2] !== 4'd9)
            $display("FAIL t6_abandoned_done_ignored count=%0d state=%0d avg=%0d expected 1 1 9",
                     sc[2], st[2], avg[2]);
        else passed++;
        en[2] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        adc  = 4'd0;
        setv = 4'd0;
        for (int d = 0; d < 3; d++) begin
            en[d]   = 1'b0;
            done[d] = 1'b0;
        end
        test_reset();
        test_basic_step();
        test_timeout();
        test_done_at_timeout();
        test_overrun();
        test_reset_mid_sample();
        test_count_wrap();
        test_single_sample();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) $display("FAIL sb_drained pending=%0d expected=0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
